smg_bcd_source_module: RTL

Sequential binary-to-BCD converter that produces the 24-bit packed-BCD Number_Sig bus consumed by the 6-digit seven-segment scan controller.
- Takes a 20-bit unsigned binary value on a Start strobe.
- Converts it with iterative shift-add-3 (double-dabble), one bit per clock.
- Holds the six-digit result stable on Number_Sig between conversions so the scan logic always sees a coherent value.

---
 rtl/smg_bcd_source_module.sv | 113 +++++++++++
 1 files changed

// File: rtl/smg_bcd_source_module.sv
// rtl/smg_bcd_source_module.sv - sequential double-dabble binary-to-BCD source for the 6-digit scan display
// Number_Sig/Overflow only move on the Done cycle so the scan logic never sees a partial result.
`timescale 1ns/1ps
module smg_bcd_source_module #(
    parameter int BIN_W   = 20,
    parameter int MAX_VAL = 999999
) (
    input  logic             CLK,
    input  logic             RSTn,
    input  logic             Start,
    input  logic [BIN_W-1:0] Binary_In,
    output logic [23:0]      Number_Sig,
    output logic             Busy,
    output logic             Done,
    output logic             Overflow
);

    typedef enum logic {
        S_IDLE,
        S_SHIFT
    } state_t;

    localparam logic [BIN_W-1:0] MAX_V = BIN_W'(MAX_VAL);
    localparam logic [4:0]       LAST  = 5'(BIN_W);

    state_t           state_q, state_d;
    logic [4:0]       cnt_q, cnt_d;
    logic [BIN_W-1:0] bin_q, bin_d;
    logic [23:0]      scr_q, scr_d;
    logic             ovf_pend_q, ovf_pend_d;
    logic [23:0]      num_q, num_d;
    logic             ovf_q, ovf_d;
    logic             done_q, done_d;

    logic [23:0]      adj;
    logic             over;

    assign over = (Binary_In > MAX_V);

    // Per-digit add-3 with no carry between digits.
    always_comb begin
        adj = scr_q;
        for (int i = 0; i < 6; i++) begin
            if (scr_q[i*4 +: 4] >= 4'd5) begin
                adj[i*4 +: 4] = scr_q[i*4 +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bin_d      = bin_q;
        scr_d      = scr_q;
        ovf_pend_d = ovf_pend_q;
        num_d      = num_q;
        ovf_d      = ovf_q;
        done_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    bin_d      = over ? MAX_V : Binary_In;
                    ovf_pend_d = over;
                    scr_d      = 24'h000000;
                    cnt_d      = 5'd0;
                    state_d    = S_SHIFT;
                end
            end
            S_SHIFT: begin
                // Counter reaching BIN_W means all bits are in; publish the result.
                if (cnt_q == LAST) begin
                    num_d   = scr_q;
                    ovf_d   = ovf_pend_q;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    scr_d = {adj[22:0], bin_q[BIN_W-1]};
                    bin_d = {bin_q[BIN_W-2:0], 1'b0};
                    cnt_d = cnt_q + 5'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q    <= S_IDLE;
            cnt_q      <= 5'd0;
            bin_q      <= '0;
            scr_q      <= 24'h000000;
            ovf_pend_q <= 1'b0;
            num_q      <= 24'h000000;
            ovf_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bin_q      <= bin_d;
            scr_q      <= scr_d;
            ovf_pend_q <= ovf_pend_d;
            num_q      <= num_d;
            ovf_q      <= ovf_d;
            done_q     <= done_d;
        end
    end

    assign Number_Sig = num_q;
    assign Overflow   = ovf_q;
    assign Done       = done_q;
    assign Busy       = (state_q == S_SHIFT);

endmodule
